// File: rtl/commit_store_buffer_if.sv
// Commit, drain and forwarding signals of the commit store buffer.
// The slave side is the buffer itself.
interface commit_store_buffer_if;
  logic [31:0] commit_value;
  logic        commit_reg_write;
  logic [31:0] commit_addr;
  logic        commit_exception;
  logic        sb_full;
  logic        sb_empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        overflow_err;

  modport slave (
    input  commit_value, commit_reg_write,
    input  commit_addr, commit_exception,
    input  mem_ack, ld_addr,
    output sb_full, sb_empty,
    output mem_req, mem_addr, mem_wdata,
    output ld_hit, ld_data, overflow_err
  );

  modport master (
    output commit_value, commit_reg_write,
    output commit_addr, commit_exception,
    output mem_ack, ld_addr,
    input  sb_full, sb_empty,
    input  mem_req, mem_addr, mem_wdata,
    input  ld_hit, ld_data, overflow_err
  );
endinterface

// File: rtl/commit_store_buffer.sv
// Post-commit store FIFO: drains retired stores to memory in order
// and forwards the youngest matching store to the load unit.
module commit_store_buffer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] IDLE_ADDR = 32'd2048
) (
  input logic clk,
  input logic rst,
  commit_store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_nxt;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [AW:0] count, count_nxt;
  logic push_req, push, pop;

  assign push_req = (bus.commit_addr != IDLE_ADDR)
                  && !bus.commit_reg_write
                  && !bus.commit_exception;
  assign pop  = (state == REQ) && bus.mem_ack;
  // a full buffer still accepts when the head retires this cycle
  assign push = push_req && ((count != FULL) || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (pop && !push)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= bus.commit_addr;
      data_q[tail] <= bus.commit_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      bus.overflow_err <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count_nxt;
      if (push_req && !push)
        bus.overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (count != '0) state_nxt = REQ;
      REQ:  if (pop && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = (state == REQ);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == REQ) begin
      bus.mem_addr  = addr_q[head];
      bus.mem_wdata = data_q[head];
    end
  end

  assign bus.sb_full  = (count == FULL);
  assign bus.sb_empty = (count == '0);

  // youngest first: tail-1 back to head
  always_comb begin
    bus.ld_hit  = 1'b0;
    bus.ld_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - AW'(i + 1);
      if (!bus.ld_hit && ((AW+1)'(i) < count)
          && addr_q[idx] == bus.ld_addr) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_commit_store_buffer.sv
// Self-checking bench for commit_store_buffer: vector tables for
// filters and lookups, a write scoreboard for the drain port.
module tb_commit_store_buffer;
  localparam logic [31:0] IDLE = 32'd2048;

  logic clk;
  logic rst;
  int errors;
  int checks;

  commit_store_buffer_if bus();

  commit_store_buffer #(.DEPTH(8), .IDLE_ADDR(IDLE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic        exc;
    logic        exp_empty;
    logic        exp_req;
  } flt_t;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } ld_t;

  wr_t  q[$];
  flt_t flt[3];
  ld_t  lds[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.commit_addr      = IDLE;
    bus.commit_value     = '0;
    bus.commit_reg_write = 1'b0;
    bus.commit_exception = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a,
                          input logic [31:0] d,
                          input bit qd);
    wr_t w;
    bus.commit_addr  = a;
    bus.commit_value = d;
    bus.commit_reg_write = 1'b0;
    bus.commit_exception = 1'b0;
    if (qd) begin
      w.a = a;
      w.d = d;
      q.push_back(w);
    end
    step();
    idle();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    bus.mem_ack = 1'b1;
    while (!(bus.sb_empty && !bus.mem_req) && n < max) begin
      step();
      n++;
    end
    bus.mem_ack = 1'b0;
    chk("drain_done", {31'd0, bus.sb_empty}, 32'd1);
  endtask

  task automatic chk_reset();
    chk("rst_empty", {31'd0, bus.sb_empty}, 32'd1);
    chk("rst_full", {31'd0, bus.sb_full}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow_err}, 32'd0);
    chk("rst_hit", {31'd0, bus.ld_hit}, 32'd0);
    chk("rst_ldata", bus.ld_data, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (!rst && bus.mem_req && bus.mem_ack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected none",
                 bus.mem_addr);
      end else begin
        w = q.pop_front();
        chk("wr_addr", bus.mem_addr, w.a);
        chk("wr_data", bus.mem_wdata, w.d);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    flt[0] = '{IDLE,        1'b0, 1'b0, 1'b1, 1'b0};
    flt[1] = '{32'h20,      1'b1, 1'b0, 1'b1, 1'b0};
    flt[2] = '{32'h30,      1'b0, 1'b1, 1'b1, 1'b0};
    lds[0] = '{32'h40, 1'b1, 32'd3};
    lds[1] = '{32'h48, 1'b0, 32'd0};
    lds[2] = '{32'h44, 1'b1, 32'd2};

    idle();
    bus.mem_ack = 1'b0;
    bus.ld_addr = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_reset();

    // single store, acked after three request cycles
    do_store(32'h10, 32'hAABBCCDD, 1'b1);
    chk("s1_req_lat", {31'd0, bus.mem_req}, 32'd0);
    chk("s1_nempty", {31'd0, bus.sb_empty}, 32'd0);
    step();
    chk("s1_req", {31'd0, bus.mem_req}, 32'd1);
    chk("s1_addr", bus.mem_addr, 32'h10);
    chk("s1_data", bus.mem_wdata, 32'hAABBCCDD);
    step();
    step();
    chk("s1_hold", bus.mem_addr, 32'h10);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("s1_empty", {31'd0, bus.sb_empty}, 32'd1);
    chk("s1_req_off", {31'd0, bus.mem_req}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      bus.commit_addr      = flt[i].addr;
      bus.commit_value     = 32'h5A5A0000 + i;
      bus.commit_reg_write = flt[i].rw;
      bus.commit_exception = flt[i].exc;
      step();
      idle();
      step();
      chk($sformatf("flt%0d_empty", i),
          {31'd0, bus.sb_empty}, {31'd0, flt[i].exp_empty});
      chk($sformatf("flt%0d_req", i),
          {31'd0, bus.mem_req}, {31'd0, flt[i].exp_req});
    end

    // fill, overflow, then back-to-back drain
    for (int i = 0; i < 8; i++)
      do_store(32'h100 + 4 * i, i, 1'b1);
    chk("fill_full", {31'd0, bus.sb_full}, 32'd1);
    chk("fill_ovf", {31'd0, bus.overflow_err}, 32'd0);
    do_store(32'h1F0, 32'hDEAD, 1'b0);
    chk("ovf_set", {31'd0, bus.overflow_err}, 32'd1);
    chk("ovf_full", {31'd0, bus.sb_full}, 32'd1);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("consec_req", {31'd0, bus.mem_req}, 32'd1);
      step();
    end
    bus.mem_ack = 1'b0;
    chk("fill_drained", {31'd0, bus.sb_empty}, 32'd1);
    chk("ovf_sticky", {31'd0, bus.overflow_err}, 32'd1);
    chk("fill_sb", q.size(), 32'd0);

    // full buffer with push and pop on the same edge
    do_reset();
    chk("pp_ovf_clr", {31'd0, bus.overflow_err}, 32'd0);
    for (int i = 0; i < 8; i++)
      do_store(32'h300 + 4 * i, 32'h1000 + i, 1'b1);
    chk("pp_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1;
    do_store(32'h200, 32'h99, 1'b1);
    bus.mem_ack = 1'b0;
    chk("pp_full", {31'd0, bus.sb_full}, 32'd1);
    chk("pp_ovf", {31'd0, bus.overflow_err}, 32'd0);
    drain(20);
    chk("pp_sb", q.size(), 32'd0);

    // youngest-match forwarding
    do_store(32'h40, 32'd1, 1'b1);
    do_store(32'h44, 32'd2, 1'b1);
    do_store(32'h40, 32'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.ld_addr = lds[i].addr;
      #1;
      chk($sformatf("ld%0d_hit", i),
          {31'd0, bus.ld_hit}, {31'd0, lds[i].hit});
      chk($sformatf("ld%0d_data", i),
          bus.ld_data, lds[i].data);
    end
    drain(10);
    bus.ld_addr = 32'h40;
    #1;
    chk("ld_gone", {31'd0, bus.ld_hit}, 32'd0);

    // reset while a request is outstanding
    do_store(32'h500, 32'd7, 1'b1);
    do_store(32'h504, 32'd8, 1'b1);
    do_store(32'h508, 32'd9, 1'b1);
    chk("mid_req", {31'd0, bus.mem_req}, 32'd1);
    bus.ld_addr = 32'h0;
    do_reset();
    chk_reset();

    // streaming stores wrap the pointers past 7 -> 0
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 10; i++)
      do_store(32'h600 + 4 * i, 32'hC0 + i, 1'b1);
    drain(20);
    chk("wrap_sb", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
